// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Also holds a saturating counter of cycles in which execute stalls a valid beat.
module id_ex_skid_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic              in_memwrite,
  input  logic              in_memtoreg,
  input  logic [FUNC_W-1:0] in_alufunc,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic [FUNC_W-1:0] out_alufunc,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic [ADDR_W-1:0] out_dest,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              regwrite;
    logic              memwrite;
    logic              memtoreg;
    logic [FUNC_W-1:0] alufunc;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] dest;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  beat_t  m_q, s_q, in_beat;
  logic   mv, sv;
  logic   acc_in, acc_out;
  logic   load_m_in, load_m_skid, load_s;

  assign in_beat = '{regwrite: in_regwrite, memwrite: in_memwrite, memtoreg: in_memtoreg,
                     alufunc: in_alufunc, src1: in_src1, src2: in_src2, dest: in_dest};

  assign mv = (state != EMPTY);
  assign sv = (state == FULL);

  // in_ready comes from registered state only, so no combinational path from out_ready.
  assign in_ready  = ~sv;
  assign out_valid = mv;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = mv & out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc_in) begin
          load_m_in = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc_in && acc_out) begin
          load_m_in = 1'b1;
        end else if (acc_out) begin
          state_nxt = EMPTY;
        end else if (acc_in) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (acc_out) begin
          load_m_skid = 1'b1;
          state_nxt   = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // NOTE: the entry registers are reset because zeroed out_* fields are visible state, not don't-cares.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)        m_q <= in_beat;
      else if (load_m_skid) m_q <= s_q;
      if (load_s)           s_q <= in_beat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cnt_clear) begin
      stall_cnt <= '0;
    end else if (mv && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Control bits are qualified by out_valid; data fields show the held entry unconditionally.
  assign out_regwrite = m_q.regwrite & mv;
  assign out_memwrite = m_q.memwrite & mv;
  assign out_memtoreg = m_q.memtoreg & mv;
  assign out_alufunc  = m_q.alufunc;
  assign out_src1     = m_q.src1;
  assign out_src2     = m_q.src2;
  assign out_dest     = m_q.dest;

endmodule
